// File: rtl/bus_master_arbiter.sv
// Shares the external bus between the CPU and NUM_REQ DMA masters: round-robin
// arbitration through the CPU dma_req/dma_ack handshake, plus a shared wait-state generator.
module bus_master_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 3,
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         owner,
  output logic               cpu_dma_req,
  input  logic               cpu_dma_ack,
  input  logic               cycle_start,
  input  logic               cycle_mem_io,
  input  logic               ext_wait,
  output logic               bus_ready,
  output logic               cycle_busy,
  output logic               hold_timeout
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned OWN_W  = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD_REQ, ST_GRANTED, ST_RELEASE} arb_state_e;
  typedef enum logic {W_IDLE, W_CNT} wait_state_e;

  arb_state_e          arb_q, arb_d;
  wait_state_e         wst_q, wst_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic                cpu_dma_req_q, cpu_dma_req_d;
  logic                hold_timeout_q, hold_timeout_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                bus_ready_q, bus_ready_d;
  logic                cycle_busy_q, cycle_busy_d;

  logic [7:0]          req_pad;
  logic [OWN_W-1:0]    cand;
  logic [OWN_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                hold_expired;
  logic                timeout_c;

  assign req_pad      = 8'(req);
  assign hold_expired = (hold_q >= HOLD_W'(HOLD_MAX - 1));

  // Round-robin search starting just after the last owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = owner_q;
    cand       = owner_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (cand == OWN_W'(NUM_REQ - 1)) ? '0 : cand + 3'd1;
      if (!pick_valid && req_pad[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) arb_q <= ST_IDLE;
    else         arb_q <= arb_d;
  end

  // Arbiter next state; a running bus cycle defers the hold timeout until it completes.
  always_comb begin
    arb_d     = arb_q;
    timeout_c = 1'b0;
    case (arb_q)
      ST_IDLE:     if (pick_valid) arb_d = ST_HOLD_REQ;
      ST_HOLD_REQ: begin
        if (!req_pad[owner_q])  arb_d = ST_RELEASE;
        else if (cpu_dma_ack)   arb_d = ST_GRANTED;
      end
      ST_GRANTED: begin
        if (!req_pad[owner_q] || !cpu_dma_ack) begin
          arb_d = ST_RELEASE;
        end else if (hold_expired && (!cycle_busy_q || bus_ready_q)) begin
          arb_d     = ST_RELEASE;
          timeout_c = 1'b1;
        end
      end
      ST_RELEASE:  if (!cpu_dma_ack) arb_d = ST_IDLE;
      default:     arb_d = ST_IDLE;
    endcase
  end

  // Arbiter outputs, registered from the next state.
  always_comb begin
    owner_d        = owner_q;
    grant_d        = '0;
    cpu_dma_req_d  = 1'b0;
    hold_timeout_d = timeout_c;
    hold_d         = '0;
    if (arb_q == ST_IDLE && pick_valid) owner_d = pick_idx;
    if (arb_d == ST_GRANTED) grant_d = NUM_REQ'(8'd1 << owner_q);
    if (arb_d == ST_HOLD_REQ || arb_d == ST_GRANTED) cpu_dma_req_d = 1'b1;
    if (arb_q == ST_GRANTED && arb_d == ST_GRANTED)
      hold_d = (hold_q == '1) ? hold_q : hold_q + 8'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner_q        <= OWN_W'(NUM_REQ - 1);
      grant_q        <= '0;
      cpu_dma_req_q  <= 1'b0;
      hold_timeout_q <= 1'b0;
      hold_q         <= '0;
    end else begin
      owner_q        <= owner_d;
      grant_q        <= grant_d;
      cpu_dma_req_q  <= cpu_dma_req_d;
      hold_timeout_q <= hold_timeout_d;
      hold_q         <= hold_d;
    end
  end

  // Wait-state generator state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) wst_q <= W_IDLE;
    else         wst_q <= wst_d;
  end

  // A cycle ends on the edge after bus_ready so cycle_busy covers the ready clock.
  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE:  if (cycle_start) wst_d = W_CNT;
      W_CNT:   if (bus_ready_q) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    bus_ready_d  = 1'b0;
    cycle_busy_d = (wst_d == W_CNT);
    case (wst_q)
      W_IDLE: begin
        if (cycle_start) cnt_d = cycle_mem_io ? WAIT_W'(MEM_WAIT) : WAIT_W'(IO_WAIT);
      end
      W_CNT: begin
        if (!bus_ready_q) begin
          if (cnt_q != '0)   cnt_d = cnt_q - 4'd1;
          else if (!ext_wait) bus_ready_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q        <= '0;
      bus_ready_q  <= 1'b0;
      cycle_busy_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bus_ready_q  <= bus_ready_d;
      cycle_busy_q <= cycle_busy_d;
    end
  end

  assign grant        = grant_q;
  assign owner        = owner_q;
  assign cpu_dma_req  = cpu_dma_req_q;
  assign hold_timeout = hold_timeout_q;
  assign bus_ready    = bus_ready_q;
  assign cycle_busy   = cycle_busy_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed scenarios plus randomized round-robin and
// wait-state traffic checked against a transaction-level model.
module tb_bus_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 1;
  localparam int unsigned IW = 3;
  localparam int unsigned HM = 8;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         cpu_dma_req;
  logic         cpu_dma_ack = 1'b0;
  logic         cycle_start = 1'b0;
  logic         cycle_mem_io = 1'b0;
  logic         ext_wait = 1'b0;
  logic         bus_ready;
  logic         cycle_busy;
  logic         hold_timeout;

  int total = 0;
  int bad   = 0;
  bit auto_ack = 1'b1;
  int model_owner = N - 1;

  bus_master_arbiter #(.NUM_REQ(N), .MEM_WAIT(MW), .IO_WAIT(IW), .HOLD_MAX(HM)) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .grant(grant), .owner(owner),
    .cpu_dma_req(cpu_dma_req), .cpu_dma_ack(cpu_dma_ack), .cycle_start(cycle_start),
    .cycle_mem_io(cycle_mem_io), .ext_wait(ext_wait), .bus_ready(bus_ready),
    .cycle_busy(cycle_busy), .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; the CPU model acknowledges whatever dma_req it sees.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) cpu_dma_ack = cpu_dma_req;
  endtask

  function automatic int rr_pick(int last, logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (grant != '0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; req = '0; cpu_dma_ack = 1'b0;
    #12;
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b exp=0", grant); end
    total++; if (owner !== 3'(N-1)) begin bad++; $display("FAIL reset_owner got=%0d exp=%0d", owner, N-1); end
    total++; if (cpu_dma_req !== 1'b0) begin bad++; $display("FAIL reset_dma_req got=%b exp=0", cpu_dma_req); end
    total++; if ({bus_ready, cycle_busy, hold_timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus_ready, cycle_busy, hold_timeout}); end
    #6 arst_n = 1'b1;
    tick();
    total++; if (grant !== '0 || cpu_dma_req !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b/%b exp=0/0", grant, cpu_dma_req); end
  endtask

  task automatic test_single();
    int e;
    e = rr_pick(model_owner, 4'b0100);
    req = 4'b0100;
    tick();
    total++; if (cpu_dma_req !== 1'b1 || grant !== '0) begin bad++; $display("FAIL single_dma_req got=%b/%b exp=1/0", cpu_dma_req, grant); end
    tick();
    total++; if (grant !== N'(1 << e)) begin bad++; $display("FAIL single_grant got=%b exp=%b", grant, N'(1 << e)); end
    total++; if (owner !== 3'(e)) begin bad++; $display("FAIL single_owner got=%0d exp=%0d", owner, e); end
    model_owner = e;
    tick(); tick();
    req = '0;
    tick();
    total++; if (grant !== '0 || cpu_dma_req !== 1'b0) begin bad++; $display("FAIL single_release got=%b/%b exp=0/0", grant, cpu_dma_req); end
    tick(); tick();
  endtask

  task automatic test_hold_req_abort();
    int e;
    auto_ack = 1'b0; cpu_dma_ack = 1'b0;
    e = rr_pick(model_owner, 4'b0010);
    req = 4'b0010;
    tick(); tick();
    total++; if (cpu_dma_req !== 1'b1 || grant !== '0) begin bad++; $display("FAIL abort_wait got=%b/%b exp=1/0", cpu_dma_req, grant); end
    total++; if (owner !== 3'(e)) begin bad++; $display("FAIL abort_owner got=%0d exp=%0d", owner, e); end
    model_owner = e;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (grant !== '0 || cpu_dma_req !== 1'b0) begin bad++; $display("FAIL abort_release got=%b/%b exp=0/0", grant, cpu_dma_req); end
    end
    auto_ack = 1'b1;
  endtask

  task automatic test_round_robin();
    bit got;
    int e;
    int h;
    logic [N-1:0] base;
    base = 4'b1101;
    req  = base;
    for (int r = 0; r < 16; r++) begin
      e = rr_pick(model_owner, req);
      wait_grant(got);
      total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL rr_grant round=%0d got=%b exp=%b", r, grant, N'(1 << e)); end
      total++; if (owner !== 3'(e)) begin bad++; $display("FAIL rr_owner round=%0d got=%0d exp=%0d", r, owner, e); end
      model_owner = e;
      h = (r < 4) ? 4 : int'($urandom_range(0, 4));
      for (int i = 0; i < h; i++) begin
        if (r >= 4) req = N'($urandom_range(0, 15)) | N'(1 << e);
        tick();
        total++; if (grant !== N'(1 << e)) begin bad++; $display("FAIL rr_hold round=%0d got=%b exp=%b", r, grant, N'(1 << e)); end
      end
      req = req & ~N'(1 << e);
      tick();
      total++; if (grant !== '0 || cpu_dma_req !== 1'b0) begin bad++; $display("FAIL rr_release round=%0d got=%b/%b exp=0/0", r, grant, cpu_dma_req); end
      req = (r < 3) ? base : N'($urandom_range(1, 15));
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    bit got;
    int e;
    req = 4'b0001;
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL to_grant got=%b exp=%b", grant, N'(1 << e)); end
    model_owner = e;
    for (int k = 1; k <= int'(HM); k++) begin
      tick();
      total++; if (hold_timeout !== (k == int'(HM))) begin bad++; $display("FAIL to_pulse k=%0d got=%b exp=%b", k, hold_timeout, k == int'(HM)); end
      total++; if (grant !== ((k < int'(HM)) ? N'(1 << e) : N'(0))) begin bad++; $display("FAIL to_revoke k=%0d got=%b", k, grant); end
    end
    req = 4'b0011;
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL to_other_first got=%b exp=%b", grant, N'(1 << e)); end
    model_owner = e;
    req = 4'b0001;
    tick();
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL to_regrant got=%b exp=%b", grant, N'(1 << e)); end
    model_owner = e;
    // req drop coinciding with HOLD_MAX is an ordinary release.
    for (int k = 1; k < int'(HM); k++) tick();
    req = '0;
    tick();
    total++; if (grant !== '0 || hold_timeout !== 1'b0) begin bad++; $display("FAIL to_simul got=%b/%b exp=0/0", grant, hold_timeout); end
    tick(); tick();
  endtask

  task automatic test_wait_states();
    int w;
    int ready_k;
    bit t;
    bit ew;
    bit exp_rdy;
    for (int c = 0; c < 14; c++) begin
      t = (c == 0) ? 1'b1 : (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      w = t ? int'(MW) : int'(IW);
      cycle_mem_io = t; cycle_start = 1'b1; ext_wait = 1'b0;
      tick();
      cycle_start = 1'b0;
      total++; if (cycle_busy !== 1'b1 || bus_ready !== 1'b0) begin bad++; $display("FAIL ws_start c=%0d got=%b/%b exp=1/0", c, cycle_busy, bus_ready); end
      ready_k = -1;
      for (int k = 1; k <= w + 12 && ready_k < 0; k++) begin
        if (c == 0)      ew = 1'b0;
        else if (c == 1) ew = (k <= 7);
        else             ew = (k > w + 8) ? 1'b0 : ($urandom_range(0, 2) == 0);
        ext_wait = ew;
        if (k == 1 && c >= 2) begin cycle_start = 1'b1; cycle_mem_io = ~t; end
        tick();
        cycle_start = 1'b0;
        exp_rdy = (k > w) && !ew;
        if (exp_rdy) ready_k = k;
        total++; if (bus_ready !== exp_rdy || cycle_busy !== 1'b1) begin bad++; $display("FAIL ws_ready c=%0d k=%0d got=%b/%b exp=%b/1", c, k, bus_ready, cycle_busy, exp_rdy); end
      end
      total++; if (ready_k < 0) begin bad++; $display("FAIL ws_never_ready c=%0d", c); end
      if (c == 0) begin total++; if (ready_k != 2) begin bad++; $display("FAIL ws_mem_lat got=%0d exp=2", ready_k); end end
      if (c == 1) begin total++; if (ready_k != 8) begin bad++; $display("FAIL ws_io_lat got=%0d exp=8", ready_k); end end
      ext_wait = 1'b0;
      tick();
      total++; if (cycle_busy !== 1'b0 || bus_ready !== 1'b0) begin bad++; $display("FAIL ws_end c=%0d got=%b/%b exp=0/0", c, cycle_busy, bus_ready); end
    end
  endtask

  task automatic test_timeout_in_cycle();
    bit got;
    int e;
    int start_k;
    int ready_k;
    int revoke_k;
    req = 4'b0100;
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL tc_grant got=%b exp=%b", grant, N'(1 << e)); end
    model_owner = e;
    start_k  = 6;
    ready_k  = start_k + int'(IW) + 1;
    revoke_k = (ready_k + 1 > int'(HM)) ? ready_k + 1 : int'(HM);
    for (int k = 1; k <= revoke_k + 1; k++) begin
      cycle_mem_io = 1'b0;
      cycle_start  = (k == start_k);
      tick();
      cycle_start = 1'b0;
      total++; if (grant !== ((k < revoke_k) ? N'(1 << e) : N'(0))) begin bad++; $display("FAIL tc_grant_k k=%0d got=%b", k, grant); end
      total++; if (hold_timeout !== (k == revoke_k) || bus_ready !== (k == ready_k)) begin bad++; $display("FAIL tc_pulse k=%0d got=%b/%b exp=%b/%b", k, hold_timeout, bus_ready, k == revoke_k, k == ready_k); end
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_ack_error();
    bit got;
    int e;
    req = 4'b1000;
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL ack_grant got=%b exp=%b", grant, N'(1 << e)); end
    model_owner = e;
    auto_ack = 1'b0; cpu_dma_ack = 1'b0;
    tick();
    total++; if (grant !== '0 || cpu_dma_req !== 1'b0 || hold_timeout !== 1'b0) begin bad++; $display("FAIL ack_drop got=%b/%b/%b exp=0/0/0", grant, cpu_dma_req, hold_timeout); end
    req = '0;
    tick(); tick();
    auto_ack = 1'b1;
  endtask

  task automatic test_async_reset();
    bit got;
    int e;
    req = 4'b0001;
    e = rr_pick(model_owner, req);
    wait_grant(got);
    total++; if (!got || grant !== N'(1 << e)) begin bad++; $display("FAIL ar_grant got=%b exp=%b", grant, N'(1 << e)); end
    cycle_mem_io = 1'b0; cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
    total++; if (cycle_busy !== 1'b1) begin bad++; $display("FAIL ar_busy got=%b exp=1", cycle_busy); end
    #2 arst_n = 1'b0;
    #1;
    total++; if (grant !== '0 || cpu_dma_req !== 1'b0 || cycle_busy !== 1'b0) begin bad++; $display("FAIL ar_async got=%b/%b/%b exp=0/0/0", grant, cpu_dma_req, cycle_busy); end
    total++; if (owner !== 3'(N-1) || bus_ready !== 1'b0) begin bad++; $display("FAIL ar_owner got=%0d/%b exp=%0d/0", owner, bus_ready, N-1); end
    req = '0; cpu_dma_ack = 1'b0;
    #10 arst_n = 1'b1;
    model_owner = N - 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (bus_ready !== 1'b0 || cycle_busy !== 1'b0) begin bad++; $display("FAIL ar_no_ready i=%0d got=%b/%b exp=0/0", i, bus_ready, cycle_busy); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_hold_req_abort();
    test_round_robin();
    test_timeout();
    test_wait_states();
    test_timeout_in_cycle();
    test_ack_error();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
